// File: rtl/mc_exec_retire.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_exec_retire : in-order retirement buffer for multi-cycle execute units
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_exec_retire #(
  parameter int NUM_UNITS = 2,
  parameter int CTX_W     = 128,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64,
  parameter int UID_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int CNT_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        issue_valid,
  input  logic [UID_W-1:0]            issue_unit,
  input  logic [CTX_W-1:0]            issue_ctx,
  output logic                        issue_ready,
  output logic [NUM_UNITS-1:0]        unit_start,
  output logic                        unit_flush,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
  output logic                        out_valid,
  output logic [CTX_W-1:0]            out_ctx,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [NUM_UNITS-1:0]        unit_busy,
  output logic [CNT_W-1:0]            occupancy,
  output logic                        timeout_err
);

  localparam int                WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [UID_W-1:0]  LAST_IDX = UID_W'(NUM_UNITS - 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [UID_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [UID_W-1:0]  q_unit_q [NUM_UNITS];
  logic [UID_W-1:0]  q_unit_d [NUM_UNITS];
  logic [CTX_W-1:0]  q_ctx_q  [NUM_UNITS];
  logic [CTX_W-1:0]  q_ctx_d  [NUM_UNITS];
  logic [DATA_W-1:0] result_q [NUM_UNITS];
  logic [DATA_W-1:0] result_d [NUM_UNITS];
  logic [NUM_UNITS-1:0] busy_q, busy_d, res_vld_q, res_vld_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;

  logic [UID_W-1:0]  head_unit;
  logic              head_res_vld;
  logic [DATA_W-1:0] head_result;
  logic              issue_unit_busy;
  logic              issue_fire;
  logic              retire;

  function automatic logic [UID_W-1:0] ptr_inc(input logic [UID_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign head_unit = q_unit_q[head_q];

  // Mux per-unit state by loop so out-of-range unit ids never index past the arrays.
  always_comb begin
    head_res_vld    = 1'b0;
    head_result     = '0;
    issue_unit_busy = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head_unit == UID_W'(u)) begin
        head_res_vld = res_vld_q[u];
        head_result  = result_q[u];
      end
      if (issue_unit == UID_W'(u)) issue_unit_busy = busy_q[u];
    end
  end

  assign issue_ready = !flush && !issue_unit_busy && (32'(issue_unit) < 32'(NUM_UNITS));
  assign issue_fire  = issue_valid && issue_ready;
  assign out_valid   = (count_q != '0) && head_res_vld;
  assign retire      = out_valid && out_ready && !flush;
  assign out_data    = out_valid ? head_result : '0;
  assign out_ctx     = out_valid ? q_ctx_q[head_q] : '0;
  assign unit_flush  = flush;
  assign unit_busy   = busy_q;
  assign occupancy   = count_q;
  assign timeout_err = err_q;

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++)
      unit_start[u] = issue_fire && (issue_unit == UID_W'(u));
  end

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    q_unit_d  = q_unit_q;
    q_ctx_d   = q_ctx_q;
    result_d  = result_q;
    busy_d    = busy_q;
    res_vld_d = res_vld_q;
    wd_d      = wd_q;
    err_d     = err_q;
    if (flush) begin
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      busy_d    = '0;
      res_vld_d = '0;
      wd_d      = '0;
      err_d     = 1'b0;
    end else begin
      // A done pulse is only meaningful for a unit waiting on its first result.
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (unit_done[u] && busy_q[u] && !res_vld_q[u]) begin
          res_vld_d[u] = 1'b1;
          result_d[u]  = unit_result[u*DATA_W +: DATA_W];
        end
        if (retire && (head_unit == UID_W'(u))) begin
          busy_d[u]    = 1'b0;
          res_vld_d[u] = 1'b0;
        end
        if (issue_fire && (issue_unit == UID_W'(u))) busy_d[u] = 1'b1;
      end
      if (retire) head_d = ptr_inc(head_q);
      if (issue_fire) begin
        q_unit_d[tail_q] = issue_unit;
        q_ctx_d[tail_q]  = issue_ctx;
        tail_d           = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_W'(issue_fire) - CNT_W'(retire);
      if (retire) begin
        wd_d = '0;
      end else if ((TIMEOUT != 0) && (count_q != '0) && !head_res_vld && (wd_q != WD_LIMIT)) begin
        wd_d = wd_q + 1'b1;
        if (wd_q + 1'b1 == WD_LIMIT) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      busy_q    <= '0;
      res_vld_q <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        q_unit_q[u] <= '0;
        q_ctx_q[u]  <= '0;
        result_q[u] <= '0;
      end
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      busy_q    <= busy_d;
      res_vld_q <= res_vld_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      q_unit_q  <= q_unit_d;
      q_ctx_q   <= q_ctx_d;
      result_q  <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_exec_retire.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mc_exec_retire : directed + randomized bench with a queue-based model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mc_exec_retire;

  localparam int NU = 2;
  localparam int CW = 128;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic [0:0]    issue_unit = '0;
  logic [CW-1:0] issue_ctx = '0;
  logic          issue_ready;
  logic [NU-1:0] unit_start;
  logic          unit_flush;
  logic [NU-1:0] unit_done = '0;
  logic [NU*DW-1:0] unit_result = '0;
  logic          out_valid;
  logic [CW-1:0] out_ctx;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic [NU-1:0] unit_busy;
  logic [1:0]    occupancy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            unit;
    logic [CW-1:0] ctx;
    bit            have;
    logic [DW-1:0] res;
  } op_t;

  op_t ops[$];
  int  wd = 0;
  bit  err = 0;

  mc_exec_retire #(.NUM_UNITS(NU), .CTX_W(CW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_unit(issue_unit), .issue_ctx(issue_ctx), .issue_ready(issue_ready),
    .unit_start(unit_start), .unit_flush(unit_flush), .unit_done(unit_done),
    .unit_result(unit_result), .out_valid(out_valid), .out_ctx(out_ctx),
    .out_data(out_data), .out_ready(out_ready), .unit_busy(unit_busy),
    .occupancy(occupancy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  // One clock cycle: compare every output against the model, then advance the model.
  task automatic tick();
    logic [NU-1:0] eb;
    logic [NU-1:0] es;
    bit            eov, er, fire, ret, waiting;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    #1;
    eb = '0;
    foreach (ops[i]) eb[ops[i].unit] = 1'b1;
    eov = (ops.size() != 0) && ops[0].have;
    ed  = eov ? ops[0].res : '0;
    ec  = eov ? ops[0].ctx : '0;
    er  = !flush && !eb[issue_unit];
    es  = (issue_valid && er) ? (2'b01 << issue_unit) : 2'b00;
    checks++;
    if ({issue_ready, unit_start, unit_busy, occupancy, out_valid, timeout_err, unit_flush} !==
        {er, es, eb, 2'(ops.size()), eov, err, flush}) begin
      errors++;
      $display("FAIL ctrl t=%0t got rdy=%b start=%b busy=%b occ=%0d ov=%b to=%b uf=%b exp rdy=%b start=%b busy=%b occ=%0d ov=%b to=%b uf=%b",
               $time, issue_ready, unit_start, unit_busy, occupancy, out_valid, timeout_err, unit_flush,
               er, es, eb, ops.size(), eov, err, flush);
    end
    checks++;
    if (out_data !== ed || out_ctx !== ec) begin
      errors++;
      $display("FAIL outbus t=%0t got data=%h ctx=%h exp data=%h ctx=%h", $time, out_data, out_ctx, ed, ec);
    end
    fire    = issue_valid && er;
    ret     = eov && out_ready && !flush;
    waiting = (ops.size() != 0) && !ops[0].have;
    @(posedge Clk);
    if (flush) begin
      ops.delete();
      wd  = 0;
      err = 0;
    end else begin
      for (int u = 0; u < NU; u++)
        if (unit_done[u])
          foreach (ops[i])
            if (ops[i].unit == u && !ops[i].have) begin
              ops[i].have = 1;
              ops[i].res  = unit_result[u*DW +: DW];
            end
      if (ret) begin
        void'(ops.pop_front());
        wd = 0;
      end else if (waiting) begin
        wd++;
        if (wd >= TO) err = 1;
      end
      if (fire) ops.push_back('{unit: int'(issue_unit), ctx: issue_ctx, have: 0, res: '0});
    end
    #1;
    issue_valid = 1'b0;
    unit_done   = '0;
    flush       = 1'b0;
  endtask

  task automatic model_clear();
    ops.delete();
    wd  = 0;
    err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_valid = 1'b0; unit_done = '0; flush = 1'b0; out_ready = 1'b1; issue_unit = '0;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (issue_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0 || unit_busy !== 2'b00 ||
        timeout_err !== 1'b0 || out_data !== '0 || out_ctx !== '0 || unit_start !== 2'b00) begin
      errors++;
      $display("FAIL reset_vals got rdy=%b ov=%b occ=%0d busy=%b to=%b data=%h start=%b exp rdy=1 ov=0 occ=0 busy=00 to=0 data=0 start=00",
               issue_ready, out_valid, occupancy, unit_busy, timeout_err, out_data, unit_start);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'hA5;
    #1;
    checks++;
    if (unit_start !== 2'b01) begin
      errors++; $display("FAIL single_start got %b exp 01", unit_start);
    end
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) begin unit_done = 2'b01; unit_result = {32'h0, 32'h1234}; end
      #1;
      checks++;
      if (out_valid !== (c == 5)) begin
        errors++; $display("FAIL single_valid cycle %0d got %b exp %b", c, out_valid, c == 5);
      end
      if (c == 5) begin
        checks++;
        if (out_data !== 32'h1234 || out_ctx !== 128'hA5) begin
          errors++; $display("FAIL single_out got data=%h ctx=%h exp data=1234 ctx=a5", out_data, out_ctx);
        end
      end
      if (c == 6) begin
        checks++;
        if (unit_busy !== 2'b00 || occupancy !== 2'd0) begin
          errors++; $display("FAIL single_drain got busy=%b occ=%0d exp busy=00 occ=0", unit_busy, occupancy);
        end
      end
      tick();
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      case (c)
        0: begin issue_valid = 1'b1; issue_unit = 1'b1; issue_ctx = 128'd1; end
        1: begin issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'd2; end
        3: begin unit_done = 2'b01; unit_result = {32'h0, 32'h22}; end
        6: begin unit_done = 2'b10; unit_result = {32'h11, 32'h0}; end
        default: ;
      endcase
      #1;
      checks++;
      if (c < 7 && out_valid !== 1'b0) begin
        errors++; $display("FAIL ooo_early cycle %0d got ov=%b exp 0", c, out_valid);
      end else if (c == 7 && (out_valid !== 1'b1 || out_data !== 32'h11 || out_ctx !== 128'd1)) begin
        errors++; $display("FAIL ooo_first got ov=%b data=%h ctx=%h exp ov=1 data=11 ctx=1", out_valid, out_data, out_ctx);
      end else if (c == 8 && (out_valid !== 1'b1 || out_data !== 32'h22 || out_ctx !== 128'd2)) begin
        errors++; $display("FAIL ooo_second got ov=%b data=%h ctx=%h exp ov=1 data=22 ctx=2", out_valid, out_data, out_ctx);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'h33;
    tick();
    unit_done = 2'b01; unit_result = {32'h0, 32'h77};
    tick();
    for (int c = 0; c < 5; c++) begin
      issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'h44;
      unit_result = {$urandom, $urandom};
      #1;
      checks++;
      if (issue_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h77 || out_ctx !== 128'h33) begin
        errors++; $display("FAIL bp_hold cycle %0d got rdy=%b ov=%b data=%h exp rdy=0 ov=1 data=77", c, issue_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    issue_valid = 1'b1; issue_unit = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL bp_retire_cycle got rdy=%b exp 0", issue_ready);
    end
    tick();
    issue_valid = 1'b1; issue_unit = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || unit_start !== 2'b01) begin
      errors++; $display("FAIL bp_reissue got rdy=%b start=%b exp rdy=1 start=01", issue_ready, unit_start);
    end
    tick();
    unit_done = 2'b01;
    tick();
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'h5;
    tick();
    issue_valid = 1'b1; issue_unit = 1'b1; issue_ctx = 128'h6;
    tick();
    for (int c = 2; c < 10; c++) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (unit_flush !== 1'b1 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got uf=%b rdy=%b exp uf=1 rdy=0", unit_flush, issue_ready);
    end
    tick();
    unit_done = 2'b11;
    #1;
    checks++;
    if (occupancy !== 2'd0 || unit_busy !== 2'b00 || unit_flush !== 1'b0) begin
      errors++; $display("FAIL flush_after got occ=%0d busy=%b uf=%b exp occ=0 busy=00 uf=0", occupancy, unit_busy, unit_flush);
    end
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_late_done got ov=%b exp 0", out_valid);
    end
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    issue_valid = 1'b1; issue_unit = 1'b0;
    tick();
    for (int c = 1; c <= 12; c++) begin
      #1;
      checks++;
      if (timeout_err !== (c >= 9)) begin
        errors++; $display("FAIL watchdog cycle %0d got %b exp %b", c, timeout_err, c >= 9);
      end
      tick();
    end
    flush = 1'b1;
    tick();
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL watchdog_clear got %b exp 0", timeout_err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_valid = 1'b1; issue_unit = 1'b0; issue_ctx = 128'h9;
    tick();
    issue_valid = 1'b1; issue_unit = 1'b1; issue_ctx = 128'hA;
    tick();
    unit_done = 2'b01; out_ready = 1'b0;
    tick();
    issue_unit = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctx !== '0 || out_data !== '0 || unit_busy !== 2'b00 ||
        occupancy !== 2'd0 || timeout_err !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got ov=%b busy=%b occ=%0d to=%b rdy=%b exp ov=0 busy=00 occ=0 to=0 rdy=1",
                         out_valid, unit_busy, occupancy, timeout_err, issue_ready);
    end
    model_clear();
    @(posedge Clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_unit  = 1'($urandom_range(0, 1));
      issue_ctx   = {$urandom, $urandom, $urandom, $urandom};
      unit_done   = {($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25)};
      unit_result = {$urandom, $urandom};
      out_ready   = ($urandom_range(0, 99) < 70);
      flush       = ($urandom_range(0, 99) < 3);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_backpressure();
    test_flush();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
